// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind MRE/MWE strobes with fixed wait states.
// Optional write protection below PROTECT_LIMIT is enabled by `define DMEM_PROTECT_EN.
module data_mem_responder #(
    parameter int          mbus          = 32,
    parameter int          AW            = 8,
    parameter int          WAIT_CYCLES   = 2,
    parameter logic [31:0] PROTECT_LIMIT = 32'h40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MRE,
    input  logic            MWE,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    output logic [mbus-1:0] loadedData,
    output logic            stall,
    output logic            err
);

    localparam int DEPTH = 2 ** AW;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [mbus-1:0] PLIM = mbus'(PROTECT_LIMIT);
`ifdef DMEM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_q, wr_q, fault_q;
    logic [AW-1:0]   idx_q;
    logic [mbus-1:0] data_q;
    logic [mbus-1:0] loaded_q, loaded_d;
    logic            err_q, err_d;
    logic [mbus-1:0] mem_q [DEPTH];

    logic            req;
    logic            in_fault;
    logic            commit;
    logic            c_rd, c_wr, c_fault;
    logic [AW-1:0]   c_idx;
    logic [mbus-1:0] c_data;
    logic            mem_we;

    assign req = MRE | MWE;

    // Dual requests and protected writes are folded into the fault flag
    always_comb begin
        in_fault = (addressData[1:0] != 2'b00)
                 | (|addressData[mbus-1:AW+2])
                 | (MRE & MWE)
                 | (PROT_EN & MWE & (addressData < PLIM));
    end

    // With zero wait states the access commits at acceptance from live inputs
    always_comb begin
        if (state_q == S_IDLE) begin
            c_rd    = MRE;
            c_wr    = MWE;
            c_fault = in_fault;
            c_idx   = addressData[AW+1:2];
            c_data  = storeData;
        end else begin
            c_rd    = rd_q;
            c_wr    = wr_q;
            c_fault = fault_q;
            c_idx   = idx_q;
            c_data  = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (ZERO_WAIT) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_we = commit & c_wr & ~c_fault;

    always_comb begin
        loaded_d = loaded_q;
        err_d    = commit & c_fault;
        if (commit && c_rd) begin
            loaded_d = c_fault ? '0 : mem_q[c_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            fault_q  <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            if (state_q == S_IDLE && req) begin
                rd_q    <= MRE;
                wr_q    <= MWE;
                fault_q <= in_fault;
                idx_q   <= addressData[AW+1:2];
                data_q  <= storeData;
            end
        end
    end

    // RAM survives reset; a write landing on a reset edge is dropped
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[c_idx] <= c_data;
        end
    end

    assign loadedData = loaded_q;
    assign err        = err_q;

endmodule
